// File: rtl/delta_event_reconstructor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delta_event_reconstructor_pkg
// Description : Channel geometry, sample types and the deadband default
//               shared by the send-on-delta encoder and the reconstructor.
// Revision    : 1.0 - initial release
// ============================================================================
package delta_event_reconstructor_pkg;

    localparam int CH_W             = 2;
    localparam int NCH              = 4;
    localparam int SAMPLE_W         = 8;
    localparam int DEADBAND_DEFAULT = 2;

    typedef logic [CH_W-1:0]     ch_idx_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/delta_event_reconstructor_slew_step.sv
`default_nettype none
// ============================================================================
// Module      : delta_slew_step
// Description : One ramp step: moves i_cur toward i_tgt by at most STEP.
//               Lands exactly on i_tgt when within reach, so it never
//               overshoots and never wraps past either end of the range.
// Revision    : 1.0 - initial release
// ============================================================================
module delta_slew_step #(
    parameter int DATA_W = 8,
    parameter int STEP   = 1
) (
    input  logic [DATA_W-1:0] i_cur,
    input  logic [DATA_W-1:0] i_tgt,
    output logic [DATA_W-1:0] o_nxt
);

    localparam logic [DATA_W:0] C_STEP = (DATA_W+1)'(STEP);

    logic signed [DATA_W:0] w_d;
    logic        [DATA_W:0] w_mag;

    always_comb begin
        w_d   = $signed({1'b0, i_tgt}) - $signed({1'b0, i_cur});
        w_mag = w_d[DATA_W] ? $unsigned(-w_d) : $unsigned(w_d);
        if (w_mag <= C_STEP) begin
            o_nxt = i_tgt;
        end else if (w_d[DATA_W]) begin
            o_nxt = i_cur - C_STEP[DATA_W-1:0];
        end else begin
            o_nxt = i_cur + C_STEP[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/delta_event_reconstructor.sv
`default_nettype none
// ============================================================================
// Module      : delta_event_reconstructor
// Description : Rebuilds 4 sample channels from send-on-delta events by
//               slewing per-channel values toward their latest targets with
//               one round-robin ramp engine. Optional staleness flags are
//               built when DELTA_STALE_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module delta_event_reconstructor
    import delta_event_reconstructor_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int STEP     = 1,
    parameter int DEADBAND = DEADBAND_DEFAULT,
    parameter int AGE_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [CH_W-1:0]   ev_ch,
    input  logic [DATA_W-1:0] ev_val,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_val,
    output logic [NCH-1:0]    settled,
    output logic              upd_pulse,
    output logic              err,
    output logic [NCH-1:0]    stale
);

    logic [DATA_W-1:0] target_q  [NCH];
    logic [DATA_W-1:0] target_d  [NCH];
    logic [DATA_W-1:0] current_q [NCH];
    logic [DATA_W-1:0] current_d [NCH];
    ch_idx_t           scan_q, scan_d;
    logic [DATA_W-1:0] rd_val_q, rd_val_d;
    logic              upd_q, upd_d;
    logic              err_q, err_d;

    logic              w_accept;
    logic [DATA_W-1:0] w_ramp_nxt;
    logic [DATA_W-1:0] w_ev_tgt;
    logic [DATA_W:0]   w_ev_diff;
    logic              w_violation;

    // rst_n is active-high: the port is closed for the whole reset cycle
    assign ev_ready = ~rst_n;
    assign w_accept = ev_valid & ev_ready;

    delta_slew_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_slew (
        .i_cur (current_q[scan_q]),
        .i_tgt (target_q[scan_q]),
        .o_nxt (w_ramp_nxt)
    );

    always_comb begin
        w_ev_tgt    = target_q[ev_ch];
        w_ev_diff   = ({1'b0, ev_val} >= {1'b0, w_ev_tgt})
                    ? ({1'b0, ev_val} - {1'b0, w_ev_tgt})
                    : ({1'b0, w_ev_tgt} - {1'b0, ev_val});
        w_violation = (w_ev_diff <= (DATA_W+1)'(DEADBAND));
    end

    // Ramp reads target_q, so an event landing on the visited channel only
    // takes effect on that channel's next visit.
    always_comb begin
        target_d          = target_q;
        current_d         = current_q;
        current_d[scan_q] = w_ramp_nxt;
        if (w_accept) begin
            target_d[ev_ch] = ev_val;
        end
        scan_d   = scan_q + 1'b1;
        rd_val_d = current_q[rd_ch];
        upd_d    = w_accept;
        err_d    = err_q | (w_accept & w_violation);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                target_q[i]  <= '0;
                current_q[i] <= '0;
            end
            scan_q   <= '0;
            rd_val_q <= '0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            current_q <= current_d;
            scan_q    <= scan_d;
            rd_val_q  <= rd_val_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        settled = '0;
        for (int i = 0; i < NCH; i++) begin
            settled[i] = (current_q[i] == target_q[i]);
        end
    end

    assign rd_val    = rd_val_q;
    assign upd_pulse = upd_q;
    assign err       = err_q;

`ifdef DELTA_STALE_DETECT_EN
    localparam logic [AGE_W-1:0] C_AGE_MAX = '1;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_age
            logic [AGE_W-1:0] age_q, age_d;

            always_comb begin
                age_d = age_q;
                if (w_accept && (ev_ch == CH_W'(gi))) begin
                    age_d = '0;
                end else if (age_q != C_AGE_MAX) begin
                    age_d = age_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    age_q <= '0;
                end else begin
                    age_q <= age_d;
                end
            end

            assign stale[gi] = (age_q == C_AGE_MAX);
        end
    endgenerate
`else
    // AGE_W is only meaningful with staleness detection; the compare is
    // always false and keeps the parameter referenced.
    assign stale = {NCH{(AGE_W < 0)}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_delta_event_reconstructor.sv
`default_nettype none
// ============================================================================
// Module      : tb_delta_event_reconstructor
// Description : Directed self-checking bench: one STEP=1 instance and one
//               STEP=64 instance sharing clock and reset, AGE_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delta_event_reconstructor;

    logic       clk;
    logic       rst_n;

    logic       ev_valid, ev_ready;
    logic [1:0] ev_ch, rd_ch;
    logic [7:0] ev_val, rd_val;
    logic [3:0] settled, stale;
    logic       upd_pulse, err;

    logic       ev64_valid, ev64_ready;
    logic [1:0] ev64_ch, rd64_ch;
    logic [7:0] ev64_val, rd64_val;
    logic [3:0] settled64, stale64;
    logic       upd64_pulse, err64;

    int n_checks;
    int n_fail;
    int cyc;

    logic [7:0] b2b_vals [4];
    logic [7:0] seq64    [4];

    delta_event_reconstructor #(
        .DATA_W (8),
        .STEP   (1),
        .AGE_W  (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_ch     (ev_ch),
        .ev_val    (ev_val),
        .rd_ch     (rd_ch),
        .rd_val    (rd_val),
        .settled   (settled),
        .upd_pulse (upd_pulse),
        .err       (err),
        .stale     (stale)
    );

    delta_event_reconstructor #(
        .DATA_W (8),
        .STEP   (64),
        .AGE_W  (4)
    ) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ev_valid  (ev64_valid),
        .ev_ready  (ev64_ready),
        .ev_ch     (ev64_ch),
        .ev_val    (ev64_val),
        .rd_ch     (rd64_ch),
        .rd_val    (rd64_val),
        .settled   (settled64),
        .upd_pulse (upd64_pulse),
        .err       (err64),
        .stale     (stale64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] val);
        ev_valid = 1'b1;
        ev_ch    = ch;
        ev_val   = val;
        step();
        ev_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] last;
        int         nchg;
        int         lastcyc;
        int         k;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        b2b_vals = '{8'd30, 8'd40, 8'd50, 8'd60};
        seq64    = '{8'd136, 8'd72, 8'd8, 8'd0};

        rst_n      = 1'b1;
        ev_valid   = 1'b0;
        ev_ch      = '0;
        ev_val     = '0;
        rd_ch      = '0;
        ev64_valid = 1'b0;
        ev64_ch    = '0;
        ev64_val   = '0;
        rd64_ch    = '0;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   32'(ev_ready),  32'd0);
        check("rst_rd_val",  32'(rd_val),    32'd0);
        check("rst_settled", 32'(settled),   32'hF);
        check("rst_err",     32'(err),       32'd0);
        check("rst_upd",     32'(upd_pulse), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rel_ready",   32'(ev_ready),  32'd1);
        cyc = 0;

        // Age saturates at 15 edges after release
        repeat (14) step();
`ifdef DELTA_STALE_DETECT_EN
        check("stale_at14", 32'(stale), 32'h0);
        step();
        check("stale_at15", 32'(stale), 32'hF);
`else
        step();
        check("stale_off",  32'(stale), 32'h0);
`endif

        // ch1 <- 10 with STEP = 1
        rd_ch = 2'd1;
        send(2'd1, 8'd10);
        check("ch1_upd_on",  32'(upd_pulse), 32'd1);
        step();
        check("ch1_upd_off", 32'(upd_pulse), 32'd0);
        last    = 8'd0;
        nchg    = 0;
        lastcyc = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (rd_val != last) begin
                check("ch1_step", 32'(rd_val), 32'(last) + 32'd1);
                if (nchg > 0) check("ch1_period", 32'(cyc - lastcyc), 32'd4);
                nchg++;
                lastcyc = cyc;
                last    = rd_val;
            end
        end
        check("ch1_final",   32'(rd_val),  32'd10);
        check("ch1_nchg",    32'(nchg),    32'd10);
        check("ch1_settled", 32'(settled), 32'hF);
        check("ch1_err",     32'(err),     32'd0);

        // Deadband violation is sticky and the target is still written
        rd_ch = 2'd0;
        send(2'd0, 8'd5);
        check("err_clean", 32'(err), 32'd0);
        send(2'd0, 8'd7);
        check("err_set",   32'(err), 32'd1);
        repeat (40) step();
        check("err_tgt7",  32'(rd_val), 32'd7);
        send(2'd0, 8'd20);
        check("err_hold1", 32'(err), 32'd1);
        repeat (60) step();
        check("ch0_20",    32'(rd_val), 32'd20);
        check("err_hold2", 32'(err), 32'd1);

        // Back-to-back events on all four channels
`ifdef DELTA_STALE_DETECT_EN
        check("stale3_before", 32'(stale[3]), 32'd1);
`endif
        ev_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ev_ch  = 2'(c);
            ev_val = b2b_vals[c];
            step();
            check("b2b_upd", 32'(upd_pulse), 32'd1);
        end
        ev_valid = 1'b0;
`ifdef DELTA_STALE_DETECT_EN
        check("stale3_clear", 32'(stale[3]), 32'd0);
`else
        check("stale_off2",   32'(stale),    32'd0);
`endif
        repeat (260) step();
        for (int c = 0; c < 4; c++) begin
            rd_ch = 2'(c);
            step();
            check("b2b_final", 32'(rd_val), 32'(b2b_vals[c]));
        end

        // Event on the channel the ramp visits in the same edge
        rd_ch = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if ((cyc % 4) != 3) step();
        end
        check("prew_align", 32'(cyc % 4), 32'd3);
        send(2'd3, 8'd100);
        check("prew_rd_pre",  32'(rd_val),     32'd60);
        check("prew_unsettl", 32'(settled[3]), 32'd0);
        step();
        check("prew_hold",    32'(rd_val),     32'd60);
        repeat (4) step();
        check("prew_next",    32'(rd_val),     32'd61);
        repeat (170) step();
        check("prew_final",   32'(rd_val),     32'd100);

        // STEP = 64: ramp up to 200, then down to 0 without wrapping
        rd64_ch    = 2'd2;
        ev64_valid = 1'b1;
        ev64_ch    = 2'd2;
        ev64_val   = 8'd200;
        step();
        ev64_valid = 1'b0;
        check("s64_upd", 32'(upd64_pulse), 32'd1);
        repeat (30) step();
        check("s64_up",  32'(rd64_val), 32'd200);
        ev64_valid = 1'b1;
        ev64_val   = 8'd0;
        step();
        ev64_valid = 1'b0;
        last = 8'd200;
        k    = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rd64_val != last) begin
                if (k < 4) check("s64_seq", 32'(rd64_val), 32'(seq64[k]));
                k++;
                last = rd64_val;
            end
        end
        check("s64_nchg",  32'(k),         32'd4);
        check("s64_final", 32'(rd64_val),  32'd0);
        check("s64_err",   32'(err64),     32'd0);
        check("s64_sett",  32'(settled64), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delta_event_reconstructor.md
Name: delta_event_reconstructor

Overview:
- Receive end of the send-on-delta change-event stream for 4 channels of 8-bit samples.
- Each event carries a channel index and a new value, and only arrives when the source moved by more than the deadband.
- Block holds a per-channel target, slews a reconstructed value toward it with a shared round-robin ramp engine, and serves reads through a registered read port.
- Optional per-channel staleness detection flags channels that have been silent too long.

Parameters:
DATA_W, 8, sample width
STEP, 1, max change of a reconstructed value per ramp visit (unsigned, 1..2^DATA_W-1)
DEADBAND, 2, encoder threshold; events with |val - target| <= DEADBAND are protocol errors
AGE_W, 8, width of per-channel age counters (used only with the optional feature)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
ev_valid  in  1  event present
ev_ready  out  1  block can accept an event
ev_ch  in  2  event channel index 0..3
ev_val  in  DATA_W  new sample value
rd_ch  in  2  read channel select
rd_val  out  DATA_W  reconstructed value of rd_ch, registered
settled  out  4  bit i = (current[i] == target[i]), combinational from state
upd_pulse  out  1  one-cycle pulse on the cycle after each accepted event
err  out  1  sticky deadband-violation flag
stale  out  4  bit i = channel i age saturated (0 when feature disabled)

Behaviour:
- Reset (rst_n=1 at clk edge):
  - All target[i], current[i], age[i] = 0; scan pointer = 0.
  - rd_val = 0, upd_pulse = 0, err = 0.
  - ev_ready = 0 in any cycle where rst_n=1, otherwise 1.
  - Reset mid-ramp abandons the ramp; there is no partial state.
- Accept:
  - An event is accepted when ev_valid && ev_ready at the edge; target[ev_ch] <= ev_val.
  - upd_pulse = 1 on the next cycle only.
  - Back-to-back events are accepted every cycle.
- Error:
  - If the accepted event has |ev_val - target[ev_ch]| <= DEADBAND, err is set and stays set until reset.
  - The target is still written.
  - Difference is computed unsigned in DATA_W+1 bits (no wrap).
- Ramp engine, one channel per cycle:
  - 2-bit scan pointer p counts 0,1,2,3,0,... and wraps.
  - For channel p: d = target[p] - current[p], signed, DATA_W+1 bits.
  - If |d| <= STEP: current[p] <= target[p].
  - Else: current[p] <= current[p] ± STEP toward target.
  - Never overshoots; never wraps past 0 or 2^DATA_W-1.
  - Each channel is updated once every 4 cycles.
- Simultaneous accept and ramp on the same channel: the ramp uses the pre-write target that cycle; the new target takes effect from the next visit.
- Read:
  - rd_val <= current[rd_ch] each cycle, 1-cycle latency.
  - A read in the same cycle as a ramp update returns the pre-update value.
- Settled:
  - Reflects registered state.
  - Reset state is all 1s (0 == 0).
- No FIFO: an accepted event overwrites any prior un-reached target.

Optional Feature:
- Macro: DELTA_STALE_DETECT_EN.
- Defined:
  - age[i] (AGE_W bits) increments every cycle, saturates at 2^AGE_W-1, clears to 0 when an event for channel i is accepted.
  - stale[i] = (age[i] == 2^AGE_W-1).
- Undefined: age counters are not built and stale = 4'b0000.

Decomposition:
- Shared package holds:
  - CH_W = 2 and NCH = 4 constants, also used by the encoder side.
  - A channel-index typedef and a sample typedef.
  - The DEADBAND default value.
- One sub-module, delta_slew_step: combinational current/target/STEP -> next current, saturating, no overshoot.
- The top holds the register file, scan pointer, handshake, error logic and age counters.

Test Plan:
- Reset held 3 cycles: ev_ready = 0, rd_val = 0, settled = 4'hF, err = 0; after release ev_ready = 1.
- Event ch1 = 8'd10 with STEP = 1: upd_pulse the next cycle; reading ch1 shows 1,2,...,10, advancing once per 4 cycles; settled[1] = 1 after 40 scan cycles; no overshoot.
- Event ch2 = 8'd200, then once settled, ch2 = 8'd0 with STEP = 64: ramp 200 -> 136 -> 72 -> 8 -> 0; no underflow wrap.
- Event ch0 = 8'd5, then ch0 = 8'd7 (diff 2 <= DEADBAND): err = 1 and stays 1; target becomes 7. A following ch0 = 8'd20 leaves err = 1.
- Four back-to-back events on ch0..ch3 on consecutive cycles, plus an event on the scan-pointed channel: all accepted; pre-write target used that cycle; final rd_val for each channel equals its event value.
- DELTA_STALE_DETECT_EN with AGE_W = 4: no event on ch3 -> stale[3] = 1 at cycle 15 after reset; an event on ch3 clears it next cycle. Build without the macro: stale stays 0.
